// File: rtl/key_toggle_bank_if.sv
// Key/LED bundle between board push-buttons and the toggle bank.
// long_press exists only when KEY_FLIP_LONGPRESS_EN is defined.
interface key_toggle_bank_if #(
    parameter int N = 4
);
    logic [N-1:0] key_in;
    logic         clr_n;
    logic [N-1:0] led;
    logic [N-1:0] state;
    logic [N-1:0] press;
`ifdef KEY_FLIP_LONGPRESS_EN
    logic [N-1:0] long_press;

    modport master (output key_in, clr_n, input led, state, press, long_press);
    modport slave  (input key_in, clr_n, output led, state, press, long_press);
`else
    modport master (output key_in, clr_n, input led, state, press);
    modport slave  (input key_in, clr_n, output led, state, press);
`endif
endinterface

// File: rtl/key_toggle_bank.sv
// N debounced toggle channels plus a shared level-sensitive clear key.
// Optional long-press "force off" per channel: define KEY_FLIP_LONGPRESS_EN.
module key_db_lane #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic deb_o
);
    localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

    logic          s1_q, s2_q, deb_q;
    logic          deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Acceptance also requires the newest sample (s1) to agree, so a level
    // must be held DB_CYC+1 samples while deb still moves DB_CYC edges after
    // the change reaches s2.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB_CYC - 1)) begin
            cnt_d = '0;
            if (s1_q == s2_q) deb_d = s2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= 1'b1;
            s2_q  <= 1'b1;
            deb_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            s1_q  <= raw_i;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign deb_o = deb_q;
endmodule

module key_toggle_bank #(
    parameter int N              = 4,
    parameter int DB_CYC         = 1000000,
    parameter int LONG_CYC       = 50000000,
    parameter int LED_ACTIVE_LOW = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    key_toggle_bank_if.slave         bus
);
    localparam logic [N-1:0] LED_OFF = (LED_ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    logic [N:0]   raw, deb;
    logic [N-1:0] key_deb;
    logic         clr_deb;
    logic [N-1:0] deb_d1_q;
    logic [N-1:0] press_d, press_q;
    logic [N-1:0] state_d, state_q;
    logic [N-1:0] led_d, led_q;
    logic [N-1:0] long_d;

    // Clear key rides on the top lane so it shares the exact key latency.
    assign raw = {bus.clr_n, bus.key_in};

    key_db_lane #(.DB_CYC(DB_CYC)) u_db [N:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_i (raw),
        .deb_o (deb)
    );

    assign key_deb = deb[N-1:0];
    assign clr_deb = deb[N];

`ifdef KEY_FLIP_LONGPRESS_EN
    localparam int HW = $clog2(LONG_CYC + 1);

    logic [N-1:0][HW-1:0] hold_q, hold_d;
    logic [N-1:0]         long_q;

    // Hold counter saturates at LONG_CYC so each hold fires exactly once.
    always_comb begin
        hold_d = hold_q;
        long_d = '0;
        for (int i = 0; i < N; i++) begin
            if (!clr_deb || key_deb[i]) begin
                hold_d[i] = '0;
            end else begin
                if (hold_q[i] == HW'(LONG_CYC - 1)) long_d[i] = 1'b1;
                if (hold_q[i] != HW'(LONG_CYC))     hold_d[i] = hold_q[i] + HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= '0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign bus.long_press = long_q;
`else
    assign long_d = '0;
`endif

    always_comb begin
        press_d = deb_d1_q & ~key_deb;
        if (!clr_deb) state_d = '0;
        else          state_d = (state_q ^ press_d) & ~long_d;
        led_d = (LED_ACTIVE_LOW != 0) ? ~state_q : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_d1_q <= '1;
            press_q  <= '0;
            state_q  <= '0;
            led_q    <= LED_OFF;
        end else begin
            deb_d1_q <= key_deb;
            press_q  <= press_d;
            state_q  <= state_d;
            led_q    <= led_d;
        end
    end

    assign bus.press = press_q;
    assign bus.state = state_q;
    assign bus.led   = led_q;
endmodule

// File: tb/tb_key_toggle_bank.sv
// Directed bench for key_toggle_bank with N=4, DB_CYC=4, LONG_CYC=20.
module tb_key_toggle_bank;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   press_cnt [N] = '{default: 0};
    int   long_cnt  [N] = '{default: 0};
    int   snap;

    key_toggle_bank_if #(.N(N)) bus ();

    key_toggle_bank #(
        .N(N), .DB_CYC(4), .LONG_CYC(20), .LED_ACTIVE_LOW(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (bus.press[i] === 1'b1) press_cnt[i]++;
`ifdef KEY_FLIP_LONGPRESS_EN
            if (bus.long_press[i] === 1'b1) long_cnt[i]++;
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input logic [N-1:0] mask, input int len);
        bus.key_in = bus.key_in & ~mask;
        cyc(len);
        bus.key_in = bus.key_in | mask;
        cyc(12);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.key_in = 4'hF;
        bus.clr_n  = 1'b1;
        cyc(3);
        chk("rst_led",   32'(bus.led),   32'hF);
        chk("rst_state", 32'(bus.state), 32'h0);
        chk("rst_press", 32'(bus.press), 32'h0);
        rst_n = 1'b1;
        cyc(50);
        chk("idle_events", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 32'd0);
        chk("idle_state",  32'(bus.state), 32'h0);
        chk("idle_led",    32'(bus.led),   32'hF);

        // single press, exact latency
        snap = press_cnt[0];
        bus.key_in[0] = 1'b0;
        cyc(6);
        chk("sp_early_press", 32'(bus.press), 32'h0);
        chk("sp_early_state", 32'(bus.state), 32'h0);
        cyc(1);
        chk("sp_press", 32'(bus.press), 32'h1);
        chk("sp_state", 32'(bus.state), 32'h1);
        cyc(1);
        chk("sp_press_1cyc", 32'(bus.press), 32'h0);
        chk("sp_led",        32'(bus.led),   32'hE);
        cyc(2);
        bus.key_in[0] = 1'b1;
        cyc(12);
        chk("sp_count",     32'(press_cnt[0] - snap), 32'd1);
        chk("sp_state_rel", 32'(bus.state), 32'h1);
        press_key(4'b0001, 10);
        chk("sp2_state", 32'(bus.state), 32'h0);
        chk("sp2_led",   32'(bus.led),   32'hF);
        chk("sp2_count", 32'(press_cnt[0] - snap), 32'd2);

        // bounce rejection
        snap = press_cnt[1];
        for (int j = 0; j < 15; j++) begin
            bus.key_in[1] = j[0];
            cyc(2);
        end
        bus.key_in[1] = 1'b1;
        cyc(12);
        chk("bounce_count", 32'(press_cnt[1] - snap), 32'd0);
        chk("bounce_state", 32'(bus.state), 32'h0);
        press_key(4'b0010, 4);
        chk("pulse4_count", 32'(press_cnt[1] - snap), 32'd0);
        chk("pulse4_state", 32'(bus.state), 32'h0);
        press_key(4'b0010, 5);
        chk("pulse5_count", 32'(press_cnt[1] - snap), 32'd1);
        chk("pulse5_state", 32'(bus.state), 32'h2);

        // simultaneous presses
        press_key(4'b0010, 8);
        press_key(4'b0101, 8);
        chk("sim_setup", 32'(bus.state), 32'h5);
        bus.key_in = 4'h0;
        cyc(6);
        chk("sim_before", 32'(bus.state), 32'h5);
        cyc(1);
        chk("sim_press", 32'(bus.press), 32'hF);
        chk("sim_state", 32'(bus.state), 32'hA);
        cyc(3);
        bus.key_in = 4'hF;
        cyc(12);
        chk("sim_hold", 32'(bus.state), 32'hA);

        // clear wins over a same-edge press
        bus.clr_n = 1'b0;
        bus.key_in[2] = 1'b0;
        cyc(6);
        chk("clr_before", 32'(bus.state), 32'hA);
        cyc(1);
        chk("clr_press", 32'(bus.press), 32'h4);
        chk("clr_state", 32'(bus.state), 32'h0);
        cyc(3);
        bus.key_in[2] = 1'b1;
        cyc(12);
        snap = press_cnt[0];
        press_key(4'b0001, 8);
        chk("clr_press_pulse", 32'(press_cnt[0] - snap), 32'd1);
        chk("clr_held_state",  32'(bus.state), 32'h0);
        bus.clr_n = 1'b1;
        cyc(12);
        chk("clr_release_state", 32'(bus.state), 32'h0);
        press_key(4'b1000, 8);
        chk("post_clr_toggle", 32'(bus.state), 32'h8);

        // reset in the middle of a debounce
        snap = press_cnt[0];
        bus.key_in[0] = 1'b0;
        cyc(3);
        rst_n = 1'b0;
        cyc(2);
        chk("mid_rst_state", 32'(bus.state), 32'h0);
        chk("mid_rst_led",   32'(bus.led),   32'hF);
        rst_n = 1'b1;
        cyc(6);
        chk("mid_rst_early", 32'(bus.press), 32'h0);
        cyc(1);
        chk("mid_rst_press", 32'(bus.press), 32'h1);
        chk("mid_rst_st",    32'(bus.state), 32'h1);
        cyc(3);
        bus.key_in[0] = 1'b1;
        cyc(12);
        chk("mid_rst_count", 32'(press_cnt[0] - snap), 32'd1);

`ifdef KEY_FLIP_LONGPRESS_EN
        snap = long_cnt[2];
        bus.key_in[2] = 1'b0;
        cyc(7);
        chk("lp_press", 32'(bus.press), 32'h4);
        chk("lp_on",    32'(bus.state), 32'h5);
        cyc(18);
        chk("lp_early", 32'(bus.long_press), 32'h0);
        chk("lp_still_on", 32'(bus.state), 32'h5);
        cyc(1);
        chk("lp_pulse", 32'(bus.long_press), 32'h4);
        chk("lp_off",   32'(bus.state), 32'h1);
        cyc(14);
        chk("lp_once", 32'(long_cnt[2] - snap), 32'd1);
        bus.key_in[2] = 1'b1;
        cyc(12);
        chk("lp_after_release", 32'(long_cnt[2] - snap), 32'd1);
        chk("lp_final_state",   32'(bus.state), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
